// File: rtl/boot_load_pkg.sv
// ============================================================================
// Module   : boot_load_pkg
// Purpose  : Shared state encoding and default geometry for the boot loader
//            sequencer and its pointer sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_load_pkg;

   // Sequencer state encoding; 6 and 7 are unused and recover to idle
   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD_IRAM = 3'd1;
   localparam logic [STATE_W-1:0] ST_LOAD_DRAM = 3'd2;
   localparam logic [STATE_W-1:0] ST_ARM       = 3'd3;
   localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE      = 3'd5;

   // Default memory geometry; address 0 is left for the processor's own use
   localparam int DEF_ADDR_W    = 9;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_BASE_ADDR = 1;

endpackage

`default_nettype wire

// File: rtl/boot_load_ctrl_load_ptr.sv
// ============================================================================
// Module   : load_ptr
// Purpose  : Per-section write pointer and word counter. Stops writing once
//            the top address has been written, counts dropped words as
//            overflow, and closes the section on the last word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_ptr
   import boot_load_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              advance_i,
   input  logic              last_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] ptr_o,
   output logic [ADDR_W-1:0] count_o,
   output logic              overflow_o
);

   localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);

   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] count_q;
   logic              full_q;     // top address already written
   logic              closed_q;   // last word of the section seen
   logic              ovf_q;
   logic              w_take;

   // A word only counts while the section is still open
   assign w_take     = advance_i & ~closed_q;
   assign wr_en_o    = w_take & ~full_q;
   assign ptr_o      = ptr_q;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

   // Pointer, counter and overflow tracking for one section
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         ptr_q    <= PTR_BASE;
         count_q  <= '0;
         full_q   <= 1'b0;
         closed_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (w_take) begin
         if (full_q) begin
            // Word arrives after the top address: dropped, no write
            ovf_q <= 1'b1;
         end else begin
            // Pointer parks on the top address instead of wrapping to 0
            if (ptr_q == PTR_MAX) begin
               full_q <= 1'b1;
            end else begin
               ptr_q <= ptr_q + 1'b1;
            end
            if (count_q != PTR_MAX) begin
               count_q <= count_q + 1'b1;
            end
         end
         if (last_i) begin
            closed_q <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/boot_load_ctrl.sv
// ============================================================================
// Module   : boot_load_ctrl
// Purpose  : Streams a program image into IRAM then DRAM, starts the
//            processor, and hands both memory ports to it until it halts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_load_ctrl
   import boot_load_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_req,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic               ld_last,
   input  logic               cpu_halt,
   input  logic [ADDR_W-1:0]  cpu_iram_addr,
   input  logic [ADDR_W-1:0]  cpu_dram_addr,
   input  logic               cpu_dram_we,
   input  logic [DATA_W-1:0]  cpu_dram_wdata,
   output logic [ADDR_W-1:0]  iram_addr,
   output logic               iram_we,
   output logic [DATA_W-1:0]  iram_wdata,
   output logic [ADDR_W-1:0]  dram_addr,
   output logic               dram_we,
   output logic [DATA_W-1:0]  dram_wdata,
   output logic               cpu_start,
   output logic [STATE_W-1:0] state_out,
   output logic [ADDR_W-1:0]  iram_count,
   output logic [ADDR_W-1:0]  dram_count,
   output logic               overflow
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;

   // Registered load write path, one set per memory
   logic               iram_ld_we_q;
   logic [ADDR_W-1:0]  iram_ld_addr_q;
   logic [DATA_W-1:0]  iram_ld_data_q;
   logic               dram_ld_we_q;
   logic [ADDR_W-1:0]  dram_ld_addr_q;
   logic [DATA_W-1:0]  dram_ld_data_q;

   logic               w_accept;
   logic               w_clear;
   logic               w_iram_adv;
   logic               w_dram_adv;
   logic               w_iram_wr;
   logic               w_dram_wr;
   logic [ADDR_W-1:0]  w_iram_ptr;
   logic [ADDR_W-1:0]  w_dram_ptr;
   logic               w_iram_ovf;
   logic               w_dram_ovf;

   assign w_accept   = ld_valid & ld_ready;
   // Starting a new load resets both sections at once
   assign w_clear    = load_req & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign w_iram_adv = w_accept & (state_q == ST_LOAD_IRAM);
   assign w_dram_adv = w_accept & (state_q == ST_LOAD_DRAM);

   load_ptr #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_iram_ptr (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (w_clear),
      .advance_i  (w_iram_adv),
      .last_i     (ld_last),
      .wr_en_o    (w_iram_wr),
      .ptr_o      (w_iram_ptr),
      .count_o    (iram_count),
      .overflow_o (w_iram_ovf)
   );

   load_ptr #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_dram_ptr (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (w_clear),
      .advance_i  (w_dram_adv),
      .last_i     (ld_last),
      .wr_en_o    (w_dram_wr),
      .ptr_o      (w_dram_ptr),
      .count_o    (dram_count),
      .overflow_o (w_dram_ovf)
   );

   assign overflow  = w_iram_ovf | w_dram_ovf;
   assign state_out = state_q;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (load_req) state_d = ST_LOAD_IRAM;
         ST_LOAD_IRAM: if (w_accept && ld_last) state_d = ST_LOAD_DRAM;
         ST_LOAD_DRAM: if (w_accept && ld_last) state_d = ST_ARM;
         ST_ARM:       state_d = ST_RUN;     // lets the final DRAM write land
         ST_RUN:       if (cpu_halt) state_d = ST_DONE;
         ST_DONE:      if (load_req) state_d = ST_LOAD_IRAM;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Registered load writes: strobe for one cycle per written word
   always_ff @(posedge clock) begin
      if (reset) begin
         iram_ld_we_q   <= 1'b0;
         iram_ld_addr_q <= '0;
         iram_ld_data_q <= '0;
         dram_ld_we_q   <= 1'b0;
         dram_ld_addr_q <= '0;
         dram_ld_data_q <= '0;
      end else begin
         iram_ld_we_q <= w_iram_wr;
         dram_ld_we_q <= w_dram_wr;
         if (w_iram_wr) begin
            iram_ld_addr_q <= w_iram_ptr;
            iram_ld_data_q <= ld_data;
         end
         if (w_dram_wr) begin
            dram_ld_addr_q <= w_dram_ptr;
            dram_ld_data_q <= ld_data;
         end
      end
   end

   // Outputs: load handshake, processor start and memory port mux
   always_comb begin
      ld_ready   = 1'b0;
      cpu_start  = 1'b0;
      iram_addr  = iram_ld_addr_q;
      iram_we    = iram_ld_we_q;
      iram_wdata = iram_ld_data_q;
      dram_addr  = dram_ld_addr_q;
      dram_we    = dram_ld_we_q;
      dram_wdata = dram_ld_data_q;
      case (state_q)
         ST_LOAD_IRAM, ST_LOAD_DRAM: begin
            ld_ready = 1'b1;
         end
         ST_RUN: begin
            cpu_start  = 1'b1;
            iram_addr  = cpu_iram_addr;
            iram_we    = 1'b0;              // IRAM is read-only to the processor
            dram_addr  = cpu_dram_addr;
            dram_we    = cpu_dram_we;
            dram_wdata = cpu_dram_wdata;
         end
         ST_DONE: begin
            // Readback only: addresses follow the processor, no writes
            iram_addr = cpu_iram_addr;
            iram_we   = 1'b0;
            dram_addr = cpu_dram_addr;
            dram_we   = 1'b0;
         end
         default: begin
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_boot_load_ctrl.sv
// ============================================================================
// Module   : tb_boot_load_ctrl
// Purpose  : Self-checking bench for boot_load_ctrl with a reference model of
//            where each streamed word must land.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_load_ctrl;

   localparam int AW   = 9;
   localparam int DW   = 16;
   localparam int BASE = 1;
   localparam int MAXW = (1 << AW) - BASE;   // words that fit in one section

   logic          clock = 1'b0;
   logic          reset;
   logic          load_req;
   logic          ld_valid;
   logic          ld_ready;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          cpu_halt;
   logic [AW-1:0] cpu_iram_addr;
   logic [AW-1:0] cpu_dram_addr;
   logic          cpu_dram_we;
   logic [DW-1:0] cpu_dram_wdata;
   logic [AW-1:0] iram_addr;
   logic          iram_we;
   logic [DW-1:0] iram_wdata;
   logic [AW-1:0] dram_addr;
   logic          dram_we;
   logic [DW-1:0] dram_wdata;
   logic          cpu_start;
   logic [2:0]    state_out;
   logic [AW-1:0] iram_count;
   logic [AW-1:0] dram_count;
   logic          overflow;

   boot_load_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .load_req       (load_req),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_data        (ld_data),
      .ld_last        (ld_last),
      .cpu_halt       (cpu_halt),
      .cpu_iram_addr  (cpu_iram_addr),
      .cpu_dram_addr  (cpu_dram_addr),
      .cpu_dram_we    (cpu_dram_we),
      .cpu_dram_wdata (cpu_dram_wdata),
      .iram_addr      (iram_addr),
      .iram_we        (iram_we),
      .iram_wdata     (iram_wdata),
      .dram_addr      (dram_addr),
      .dram_we        (dram_we),
      .dram_wdata     (dram_wdata),
      .cpu_start      (cpu_start),
      .state_out      (state_out),
      .iram_count     (iram_count),
      .dram_count     (dram_count),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory model: what the two RAMs would hold, captured mid-cycle
   logic [DW-1:0] mi [512];
   logic [DW-1:0] md [512];
   bit            wi [512];
   bit            wd [512];
   int            niw;
   int            ndw;

   always @(negedge clock) begin
      if (iram_we === 1'b1) begin
         niw++;
         mi[iram_addr] = iram_wdata;
         wi[iram_addr] = 1'b1;
      end
      if (dram_we === 1'b1) begin
         ndw++;
         md[dram_addr] = dram_wdata;
         wd[dram_addr] = 1'b1;
      end
   end

   logic [DW-1:0] qi [$];
   logic [DW-1:0] qd [$];

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Presents one word and holds it until the edge that accepts it
   task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         @(negedge clock);
         ld_valid = 1'b0;
         @(posedge clock);
      end
      @(negedge clock);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      t = 0;
      while (ld_ready !== 1'b1 && t < 20) begin
         @(negedge clock);
         t++;
      end
      chk("ld_ready", {31'd0, ld_ready}, 32'd1);
      @(posedge clock);
   endtask

   task automatic start_load();
      @(negedge clock);
      load_req = 1'b1;
      @(posedge clock);
      #1;
      load_req = 1'b0;
      chk("start_state", {29'd0, state_out}, 32'd1);
      chk("start_icnt", {23'd0, iram_count}, 32'd0);
      chk("start_dcnt", {23'd0, dram_count}, 32'd0);
      chk("start_ovf", {31'd0, overflow}, 32'd0);
      niw = 0;
      ndw = 0;
      for (int a = 0; a < 512; a++) begin
         wi[a] = 1'b0;
         wd[a] = 1'b0;
      end
   endtask

   // Streams qi then qd, checks timing to RUN and the resulting memory image
   task automatic do_load(input int fixed_gap, input int rand_gap);
      int ni;
      int nd;
      int ei;
      int ed;
      ni = qi.size();
      nd = qd.size();
      ei = min_i(ni, MAXW);
      ed = min_i(nd, MAXW);
      for (int i = 0; i < ni; i++)
         send_word(qi[i], (i == ni - 1), fixed_gap + int'($urandom_range(0, rand_gap)));
      #1;
      chk("st_ldram", {29'd0, state_out}, 32'd2);
      chk("icnt_mid", {23'd0, iram_count}, ei);
      chk("ovf_mid", {31'd0, overflow}, (ni > MAXW) ? 32'd1 : 32'd0);
      for (int i = 0; i < nd; i++)
         send_word(qd[i], (i == nd - 1), fixed_gap + int'($urandom_range(0, rand_gap)));
      #1;
      chk("st_arm", {29'd0, state_out}, 32'd3);
      chk("arm_start", {31'd0, cpu_start}, 32'd0);
      chk("arm_ready", {31'd0, ld_ready}, 32'd0);
      @(negedge clock);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      @(posedge clock);
      #1;
      chk("st_run", {29'd0, state_out}, 32'd4);
      chk("run_start", {31'd0, cpu_start}, 32'd1);
      chk("icnt", {23'd0, iram_count}, ei);
      chk("dcnt", {23'd0, dram_count}, ed);
      chk("ovf", {31'd0, overflow}, ((ni > MAXW) || (nd > MAXW)) ? 32'd1 : 32'd0);
      chk("iwr_n", niw, ei);
      chk("dwr_n", ndw, ed);
      chk("iaddr0", {31'd0, wi[0]}, 32'd0);
      chk("daddr0", {31'd0, wd[0]}, 32'd0);
      for (int i = 0; i < ei; i++)
         chk("imem", {16'd0, mi[BASE + i]}, {16'd0, qi[i]});
      for (int i = 0; i < ed; i++)
         chk("dmem", {16'd0, md[BASE + i]}, {16'd0, qd[i]});
   endtask

   task automatic do_halt();
      logic [AW-1:0] a;
      @(negedge clock);
      cpu_halt = 1'b1;
      @(posedge clock);
      #1;
      cpu_halt = 1'b0;
      chk("st_done", {29'd0, state_out}, 32'd5);
      chk("done_start", {31'd0, cpu_start}, 32'd0);
      a = AW'($urandom_range(0, 511));
      cpu_dram_addr = a;
      cpu_dram_we   = 1'b1;
      #1;
      chk("done_daddr", {23'd0, dram_addr}, {23'd0, a});
      chk("done_dwe", {31'd0, dram_we}, 32'd0);
      cpu_dram_we = 1'b0;
   endtask

   task automatic rand_sections(input int maxn);
      qi.delete();
      qd.delete();
      repeat ($urandom_range(1, maxn)) qi.push_back(DW'($urandom));
      repeat ($urandom_range(1, maxn)) qd.push_back(DW'($urandom));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [AW-1:0] ia;
      reset          = 1'b1;
      load_req       = 1'b0;
      ld_valid       = 1'b0;
      ld_data        = '0;
      ld_last        = 1'b0;
      cpu_halt       = 1'b0;
      cpu_iram_addr  = '0;
      cpu_dram_addr  = '0;
      cpu_dram_we    = 1'b0;
      cpu_dram_wdata = '0;
      niw = 0;
      ndw = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_state", {29'd0, state_out}, 32'd0);
      chk("rst_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_iwe", {31'd0, iram_we}, 32'd0);
      chk("rst_dwe", {31'd0, dram_we}, 32'd0);
      chk("rst_start", {31'd0, cpu_start}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_iaddr", {23'd0, iram_addr}, 32'd0);
      chk("rst_daddr", {23'd0, dram_addr}, 32'd0);
      chk("rst_iwd", {16'd0, iram_wdata}, 32'd0);
      chk("rst_icnt", {23'd0, iram_count}, 32'd0);
      chk("rst_dcnt", {23'd0, dram_count}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Directed load and start
      start_load();
      qi = '{16'd100, 16'd200, 16'd300};
      qd = '{16'd7, 16'd9};
      do_load(0, 0);

      // Port mux in RUN
      @(negedge clock);
      ia = AW'($urandom_range(0, 511));
      cpu_iram_addr  = ia;
      cpu_dram_we    = 1'b1;
      cpu_dram_addr  = 9'd5;
      cpu_dram_wdata = 16'hABCD;
      #1;
      chk("run_dwe", {31'd0, dram_we}, 32'd1);
      chk("run_daddr", {23'd0, dram_addr}, 32'd5);
      chk("run_dwd", {16'd0, dram_wdata}, 32'h0000ABCD);
      chk("run_iwe", {31'd0, iram_we}, 32'd0);
      chk("run_iaddr", {23'd0, iram_addr}, {23'd0, ia});
      @(negedge clock);
      cpu_dram_we = 1'b0;

      // load_req ignored while running
      load_req = 1'b1;
      @(posedge clock);
      #1;
      load_req = 1'b0;
      chk("run_ignore_req", {29'd0, state_out}, 32'd4);
      do_halt();

      // Throttled load: valid high every other cycle
      start_load();
      qi = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      qd = '{16'h5555};
      do_load(1, 0);
      do_halt();

      // Overflow: 512 IRAM words, the last one is dropped
      start_load();
      qi.delete();
      qd.delete();
      for (int i = 0; i < 512; i++) qi.push_back(DW'($urandom));
      qd.push_back(DW'($urandom));
      do_load(0, 0);
      do_halt();

      // Reload clears overflow; cpu writes ignored while loading
      start_load();
      @(negedge clock);
      cpu_dram_we    = 1'b1;
      cpu_dram_addr  = 9'd5;
      cpu_dram_wdata = 16'hABCD;
      #1;
      chk("ld_dwe_blocked", {31'd0, dram_we}, 32'd0);
      cpu_dram_we = 1'b0;

      // Mid-load reset inside LOAD_DRAM
      rand_sections(6);
      for (int i = 0; i < qi.size(); i++)
         send_word(qi[i], (i == qi.size() - 1), 0);
      send_word(16'h0BAD, 1'b0, 0);
      #1;
      chk("pre_rst_state", {29'd0, state_out}, 32'd2);
      @(negedge clock);
      ld_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      chk("mrst_state", {29'd0, state_out}, 32'd0);
      chk("mrst_ready", {31'd0, ld_ready}, 32'd0);
      chk("mrst_iwe", {31'd0, iram_we}, 32'd0);
      chk("mrst_dwe", {31'd0, dram_we}, 32'd0);
      chk("mrst_icnt", {23'd0, iram_count}, 32'd0);
      chk("mrst_dcnt", {23'd0, dram_count}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Randomized sections, gaps and data
      repeat (6) begin
         start_load();
         rand_sections(24);
         do_load(0, 2);
         do_halt();
      end

      repeat (2) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
